// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: FSM state encodings and the enable
// vectors ordered {PC, IF_ID, ID_EX, EX_M}.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    BR_WAIT  = 2'b10,
    MISS     = 2'b11
  } state_e;

  localparam logic [3:0] EN_GO     = 4'b1111;
  localparam logic [3:0] EN_STALL  = 4'b0011;
  localparam logic [3:0] EN_FREEZE = 4'b0000;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX until cleared
// or reset.
module sat_counter #(
  parameter int         W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && (r_q != MAX)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: decodes hazards,
// branch resolution and cache readiness into register enables and flushes.
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int LU_CYCLES    = 1,
  parameter int BR_CYCLES    = 2,
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cache_Ready,
  input  logic             hazard,
  input  logic             PC_hazard,
  input  logic             j_cntrl,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_M_en,
  output logic [1:0]       state,
  output logic             miss_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAXC = (LU_CYCLES > BR_CYCLES) ? LU_CYCLES : BR_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam int MW   = $clog2(MISS_TIMEOUT + 1);
  localparam logic [CW-1:0] LU_LOAD = (LU_CYCLES > 1) ? CW'(LU_CYCLES - 2) : '0;
  localparam logic [CW-1:0] BR_LOAD = (BR_CYCLES > 1) ? CW'(BR_CYCLES - 2) : '0;

  state_e          r_state;
  state_e          w_next_state;
  state_e          r_ret_state;
  state_e          w_next_ret;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_next_cnt;
  logic [3:0]      w_en;
  logic            w_if_flush;
  logic            w_id_flush;
  logic            w_miss_inc;
  logic            w_miss_clr;
  logic [MW-1:0]   w_miss_cnt;
  logic            r_miss_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next_state;
      r_ret_state <= w_next_ret;
      r_cnt       <= w_next_cnt;
    end
  end

  // A miss in any state freezes everything; the wait count is preserved so
  // the interrupted stall resumes exactly where it left off.
  always_comb begin
    w_next_state = r_state;
    w_next_ret   = r_ret_state;
    w_next_cnt   = r_cnt;
    w_en         = EN_GO;
    w_if_flush   = 1'b0;
    w_id_flush   = 1'b0;
    w_miss_inc   = 1'b0;
    w_miss_clr   = 1'b0;

    if (r_state == MISS) begin
      w_en = EN_FREEZE;
      if (cache_Ready) begin
        w_next_state = r_ret_state;
        w_miss_clr   = 1'b1;
      end else begin
        w_miss_inc = 1'b1;
      end
    end else if (!cache_Ready) begin
      w_en         = EN_FREEZE;
      w_next_ret   = r_state;
      w_next_state = MISS;
    end else begin
      case (r_state)
        RUN: begin
          if (hazard) begin
            w_en       = EN_STALL;
            w_id_flush = 1'b1;
            if (LU_CYCLES > 1) begin
              w_next_cnt   = LU_LOAD;
              w_next_state = LU_STALL;
            end
          end else if (PC_hazard) begin
            w_en       = EN_STALL;
            w_id_flush = 1'b1;
            if (BR_CYCLES > 1) begin
              w_next_cnt   = BR_LOAD;
              w_next_state = BR_WAIT;
            end
          end else if (j_cntrl) begin
            w_if_flush = 1'b1;
          end
        end
        LU_STALL: begin
          w_en       = EN_STALL;
          w_id_flush = 1'b1;
          if (r_cnt == '0) begin
            w_next_state = RUN;
          end else begin
            w_next_cnt = r_cnt - 1'b1;
          end
        end
        BR_WAIT: begin
          if (r_cnt != '0) begin
            w_en       = EN_STALL;
            w_id_flush = 1'b1;
            w_next_cnt = r_cnt - 1'b1;
          end else begin
            w_if_flush   = j_cntrl;
            w_next_state = RUN;
          end
        end
        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

  sat_counter #(
    .W   (MW),
    .MAX (MW'(MISS_TIMEOUT))
  ) u_miss_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (w_miss_inc),
    .clr   (w_miss_clr),
    .q     (w_miss_cnt)
  );

  // Flag rises on the same edge the miss counter reaches the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_miss_err <= 1'b0;
    end else if (w_miss_inc && (w_miss_cnt >= MW'(MISS_TIMEOUT - 1))) begin
      r_miss_err <= 1'b1;
    end
  end

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (~PC_en),
    .clr   (1'b0),
    .q     (stall_cycles)
  );

  assign {PC_en, IF_ID_en, ID_EX_en, EX_M_en} = reset ? w_en : 4'b0000;
  assign IF_ID_flush = reset & w_if_flush;
  assign ID_EX_flush = reset & w_id_flush;
  assign state       = r_state;
  assign miss_err    = r_miss_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with LU_CYCLES=2, BR_CYCLES=2,
// MISS_TIMEOUT=4; each scenario task carries its own expected values.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cache_Ready = 1'b1;
  logic        hazard = 1'b0;
  logic        PC_hazard = 1'b0;
  logic        j_cntrl = 1'b0;
  logic        PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_M_en;
  logic [1:0]  state;
  logic        miss_err;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  // {PC_en, IF_ID_en, ID_EX_en, EX_M_en, IF_ID_flush, ID_EX_flush}
  localparam logic [5:0] GO     = 6'b111100;
  localparam logic [5:0] GO_FL  = 6'b111110;
  localparam logic [5:0] STALL  = 6'b001101;
  localparam logic [5:0] FREEZE = 6'b000000;

  logic [5:0] outs;
  assign outs = {PC_en, IF_ID_en, ID_EX_en, EX_M_en, IF_ID_flush, ID_EX_flush};

  pipeline_ctrl #(
    .LU_CYCLES    (2),
    .BR_CYCLES    (2),
    .MISS_TIMEOUT (4),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cache_Ready  (cache_Ready),
    .hazard       (hazard),
    .PC_hazard    (PC_hazard),
    .j_cntrl      (j_cntrl),
    .PC_en        (PC_en),
    .IF_ID_en     (IF_ID_en),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_en     (ID_EX_en),
    .ID_EX_flush  (ID_EX_flush),
    .EX_M_en      (EX_M_en),
    .state        (state),
    .miss_err     (miss_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after the edge; outputs are observed 2 later.
  task automatic drive(input logic [3:0] in);
    {cache_Ready, hazard, PC_hazard, j_cntrl} = in;
    #2;
  endtask

  task automatic resetDut;
    reset = 1'b0;
    drive(4'b1000);
    tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #2;
    vectors++;
    if (outs !== FREEZE) begin
      miscompares++;
      $display("FAIL rst_outs got %b want %b", outs, FREEZE);
    end
    vectors++;
    if (state !== 2'b00 || stall_cycles !== 16'd0 || miss_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_regs got st=%b sc=%0d me=%b want 00/0/0", state, stall_cycles, miss_err);
    end
    tick;
    reset = 1'b1;
    drive(4'b1000);
    vectors++;
    if (outs !== GO || state !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_release got %b/%b want %b/00", outs, state, GO);
    end
    tick;
    drive(4'b1100);
    tick;
    drive(4'b1000);
    vectors++;
    if (state !== 2'b01 || outs !== STALL) begin
      miscompares++;
      $display("FAIL rst_pre got %b/%b want %b/01", outs, state, STALL);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (outs !== FREEZE || state !== 2'b00 || stall_cycles !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid got %b/%b/%0d want %b/00/0", outs, state, stall_cycles, FREEZE);
    end
    tick;
    reset = 1'b1;
    drive(4'b1000);
    vectors++;
    if (outs !== GO || state !== 2'b00 || stall_cycles !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_after got %b/%b/%0d want %b/00/0", outs, state, stall_cycles, GO);
    end
    tick;
  endtask

  task automatic test_load_use;
    logic [3:0] in [3] = '{4'b1100, 4'b1000, 4'b1000};
    logic [5:0] eo [3] = '{STALL, STALL, GO};
    logic [1:0] es [3] = '{2'b00, 2'b01, 2'b00};
    resetDut;
    for (int i = 0; i < 3; i++) begin
      drive(in[i]);
      vectors++;
      if (outs !== eo[i] || state !== es[i]) begin
        miscompares++;
        $display("FAIL lu[%0d] got %b/%b want %b/%b", i, outs, state, eo[i], es[i]);
      end
      tick;
    end
    vectors++;
    if (stall_cycles !== 16'd2) begin
      miscompares++;
      $display("FAIL lu_stall_cycles got %0d want 2", stall_cycles);
    end
  endtask

  task automatic test_branch;
    logic [3:0] in [3] = '{4'b1010, 4'b1011, 4'b1000};
    logic [5:0] eo [3] = '{STALL, GO_FL, GO};
    logic [1:0] es [3] = '{2'b00, 2'b10, 2'b00};
    resetDut;
    for (int i = 0; i < 3; i++) begin
      drive(in[i]);
      vectors++;
      if (outs !== eo[i] || state !== es[i]) begin
        miscompares++;
        $display("FAIL br[%0d] got %b/%b want %b/%b", i, outs, state, eo[i], es[i]);
      end
      tick;
    end
    vectors++;
    if (stall_cycles !== 16'd1) begin
      miscompares++;
      $display("FAIL br_stall_cycles got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_miss_resume;
    logic [3:0] in [7] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000};
    logic [5:0] eo [7] = '{STALL, FREEZE, FREEZE, FREEZE, FREEZE, STALL, GO};
    logic [1:0] es [7] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    resetDut;
    for (int i = 0; i < 7; i++) begin
      drive(in[i]);
      vectors++;
      if (outs !== eo[i] || state !== es[i]) begin
        miscompares++;
        $display("FAIL miss[%0d] got %b/%b want %b/%b", i, outs, state, eo[i], es[i]);
      end
      tick;
    end
    vectors++;
    if (stall_cycles !== 16'd6 || miss_err !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_regs got sc=%0d me=%b want 6/0", stall_cycles, miss_err);
    end
  endtask

  task automatic test_timeout;
    resetDut;
    for (int i = 0; i < 6; i++) begin
      drive(4'b0000);
      vectors++;
      if (outs !== FREEZE || state !== ((i == 0) ? 2'b00 : 2'b11) || miss_err !== (i >= 5)) begin
        miscompares++;
        $display("FAIL to[%0d] got %b/%b/%b want %b/%b/%b", i, outs, state, miss_err,
                 FREEZE, ((i == 0) ? 2'b00 : 2'b11), (i >= 5));
      end
      tick;
    end
    drive(4'b1000);
    vectors++;
    if (outs !== FREEZE || state !== 2'b11 || miss_err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_recover got %b/%b/%b want %b/11/1", outs, state, miss_err, FREEZE);
    end
    tick;
    drive(4'b1000);
    vectors++;
    if (outs !== GO || state !== 2'b00 || miss_err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_sticky got %b/%b/%b want %b/00/1", outs, state, miss_err, GO);
    end
    tick;
    resetDut;
    drive(4'b1000);
    vectors++;
    if (miss_err !== 1'b0) begin
      miscompares++;
      $display("FAIL to_cleared got %b want 0", miss_err);
    end
    tick;
  endtask

  task automatic test_priority;
    logic [3:0] in [5] = '{4'b0111, 4'b1111, 4'b1111, 4'b1000, 4'b1000};
    logic [5:0] eo [5] = '{FREEZE, FREEZE, STALL, STALL, GO};
    logic [1:0] es [5] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b00};
    resetDut;
    for (int i = 0; i < 5; i++) begin
      drive(in[i]);
      vectors++;
      if (outs !== eo[i] || state !== es[i]) begin
        miscompares++;
        $display("FAIL prio[%0d] got %b/%b want %b/%b", i, outs, state, eo[i], es[i]);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_miss_resume;
    test_timeout;
    test_priority;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
